i2c_master_bit_engine: RTL

- Parametrised I2C master command engine; successor to the fixed 8-bit, 16-bit-divisor single-byte data path.
- Executes START, STOP, WRITE and READ commands on an open-drain SCL/SDA pair.
- Each bit is split into four timed phases, data1 to data4. The block adds multi-width frames, read with ACK/NACK generation, repeated start and SCL clock stretching.
- Sits between the host command interface and the pad open-drain drivers.

---
 rtl/i2c_master_bit_engine_if.sv | 33 +++
 rtl/i2c_master_bit_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_bit_engine_if.sv
// Host command / response bus and open-drain pad levels for the I2C master bit engine.
interface i2c_master_bit_engine_if #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DIV_WIDTH-1:0]  clock_divisor;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_nack;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_ack;
  logic                  rsp_err;
  logic                  scl_in;
  logic                  sda_in;
  logic                  scl_out;
  logic                  sda_out;
  logic                  busy;

  // Host and pad environment side.
  modport master (
    output clock_divisor, cmd_valid, cmd_op, cmd_data, cmd_nack, scl_in, sda_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ack, rsp_err, scl_out, sda_out, busy
  );

  // Engine side.
  modport slave (
    input  clock_divisor, cmd_valid, cmd_op, cmd_data, cmd_nack, scl_in, sda_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_ack, rsp_err, scl_out, sda_out, busy
  );
endinterface

// File: rtl/i2c_master_bit_engine.sv
// I2C master command engine: START/STOP/WRITE/READ on open-drain SCL/SDA,
// four timed phases per bit, ACK/NACK on reads, repeated start and clock stretching.
module i2c_master_bit_engine #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_master_bit_engine_if.slave bus
);

  localparam int unsigned TX_W  = DATA_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 2);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HOLD,
    S_START0,
    S_START1,
    S_START2,
    S_START3,
    S_STOP1,
    S_STOP2,
    S_STOP3,
    S_DATA1,
    S_DATA2,
    S_DATA3,
    S_DATA4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIV_WIDTH-1:0]  r_ctr;
  logic [DIV_WIDTH-1:0]  w_ctr_nxt;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  w_div_nxt;
  logic [TX_W-1:0]       r_tx;
  logic [TX_W-1:0]       w_tx_nxt;
  logic [TX_W-1:0]       r_rx;
  logic [TX_W-1:0]       w_rx_nxt;
  logic [CNT_W-1:0]      r_bitcnt;
  logic [CNT_W-1:0]      w_bitcnt_nxt;
  logic [1:0]            r_op;
  logic [1:0]            w_op_nxt;
  logic                  r_nack;
  logic                  w_nack_nxt;
  logic                  r_scl;
  logic                  w_scl_nxt;
  logic                  r_sda;
  logic                  w_sda_nxt;
  logic                  r_cmd_ready;
  logic                  w_cmd_ready_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_rsp_valid;
  logic                  w_rsp_valid_nxt;
  logic                  r_rsp_err;
  logic                  w_rsp_err_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [DATA_WIDTH-1:0] w_rsp_data_nxt;
  logic                  r_rsp_ack;
  logic                  w_rsp_ack_nxt;

  logic                  w_stretch;
  logic                  w_phase_end;
  logic                  w_accept;
  logic                  w_bit;

  // A released SCL held low by a slave freezes the phase timer.
  assign w_stretch   = r_scl && !bus.scl_in;
  assign w_phase_end = (r_ctr == r_div) && !w_stretch;
  assign w_accept    = bus.cmd_valid && r_cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ctr       <= '0;
      r_div       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_bitcnt    <= '0;
      r_op        <= OP_START;
      r_nack      <= 1'b0;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_ack   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ctr       <= w_ctr_nxt;
      r_div       <= w_div_nxt;
      r_tx        <= w_tx_nxt;
      r_rx        <= w_rx_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_op        <= w_op_nxt;
      r_nack      <= w_nack_nxt;
      r_scl       <= w_scl_nxt;
      r_sda       <= w_sda_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_ack   <= w_rsp_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ctr_nxt       = r_ctr;
    w_div_nxt       = r_div;
    w_tx_nxt        = r_tx;
    w_rx_nxt        = r_rx;
    w_bitcnt_nxt    = r_bitcnt;
    w_op_nxt        = r_op;
    w_nack_nxt      = r_nack;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_ack_nxt   = r_rsp_ack;
    w_bit           = 1'b1;
    w_scl_nxt       = 1'b1;
    w_sda_nxt       = 1'b1;
    w_cmd_ready_nxt = 1'b0;
    w_busy_nxt      = 1'b1;

    if (r_state != S_IDLE && r_state != S_HOLD && !w_stretch) begin
      w_ctr_nxt = (r_ctr == r_div) ? '0 : r_ctr + DIV_WIDTH'(1);
    end

    if (w_accept) begin
      w_div_nxt  = bus.clock_divisor;
      w_tx_nxt   = {bus.cmd_data, 1'b1};
      w_op_nxt   = bus.cmd_op;
      w_nack_nxt = bus.cmd_nack;
      w_ctr_nxt  = '0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.cmd_op == OP_START) begin
            w_state_nxt = S_START1;
          end else begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_START: w_state_nxt = S_START0;
            OP_STOP:  w_state_nxt = S_STOP1;
            OP_WRITE, OP_READ: begin
              w_state_nxt  = S_DATA1;
              w_bitcnt_nxt = '0;
              w_rx_nxt     = '0;
            end
            default: w_state_nxt = S_HOLD;
          endcase
        end
      end
      S_START0: if (w_phase_end) w_state_nxt = S_START1;
      S_START1: if (w_phase_end) w_state_nxt = S_START2;
      S_START2: if (w_phase_end) w_state_nxt = S_START3;
      S_START3: begin
        if (w_phase_end) begin
          w_state_nxt     = S_HOLD;
          w_rsp_valid_nxt = 1'b1;
        end
      end
      S_STOP1: if (w_phase_end) w_state_nxt = S_STOP2;
      S_STOP2: if (w_phase_end) w_state_nxt = S_STOP3;
      S_STOP3: begin
        if (w_phase_end) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b1;
        end
      end
      S_DATA1: if (w_phase_end) w_state_nxt = S_DATA2;
      S_DATA2: if (w_phase_end) w_state_nxt = S_DATA3;
      S_DATA3: begin
        // Sample on the last cycle of the SCL-high window.
        if (w_phase_end) begin
          w_rx_nxt    = {r_rx[TX_W-2:0], bus.sda_in};
          w_state_nxt = S_DATA4;
        end
      end
      S_DATA4: begin
        if (w_phase_end) begin
          w_tx_nxt     = {r_tx[TX_W-2:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
          if (r_bitcnt == CNT_W'(DATA_WIDTH)) begin
            w_state_nxt     = S_HOLD;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = r_rx[TX_W-1:1];
            w_rsp_ack_nxt   = r_rx[0];
          end else begin
            w_state_nxt = S_DATA1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Bit driven in the next state, taken from the post-shift frame registers.
    if (w_op_nxt == OP_WRITE) begin
      w_bit = w_tx_nxt[TX_W-1];
    end else if (w_bitcnt_nxt == CNT_W'(DATA_WIDTH)) begin
      w_bit = w_nack_nxt;
    end

    case (w_state_nxt)
      S_HOLD: begin
        w_scl_nxt = 1'b0;
        w_sda_nxt = r_sda;
      end
      S_START0: w_scl_nxt = 1'b0;
      S_START2: w_sda_nxt = 1'b0;
      S_START3, S_STOP1: begin
        w_scl_nxt = 1'b0;
        w_sda_nxt = 1'b0;
      end
      S_STOP2: w_sda_nxt = 1'b0;
      S_DATA1, S_DATA4: begin
        w_scl_nxt = 1'b0;
        w_sda_nxt = w_bit;
      end
      S_DATA2, S_DATA3: w_sda_nxt = w_bit;
      default: begin
        w_scl_nxt = 1'b1;
        w_sda_nxt = 1'b1;
      end
    endcase

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_HOLD);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_ack   = r_rsp_ack;
  assign bus.scl_out   = r_scl;
  assign bus.sda_out   = r_sda;
  assign bus.busy      = r_busy;

endmodule
